// File: rtl/evt_drv_pkg.sv
`default_nettype none
// ============================================================================
// Package : evt_drv_pkg
// Desc    : Shared state encoding and error codes for the event/level driver.
// Rev     : 1.0  initial release
// ============================================================================
package evt_drv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GAP1    = 3'd1,
    WAIT_HI = 3'd2,
    TOGGLE  = 3'd3,
    GAPN    = 3'd4,
    WAIT_LO = 3'd5,
    FIN     = 3'd6
  } evt_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_RISE = 2'b01;
  localparam logic [1:0] ERR_NO_FALL = 2'b10;

endpackage
`default_nettype wire

// File: rtl/evt_down_timer.sv
`default_nettype none
// ============================================================================
// Module : evt_down_timer
// Desc   : Loadable down-counter that saturates at zero, with current and
//          next-cycle zero flags.
// Rev    : 1.0  initial release
// ============================================================================
module evt_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_next_zero
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_cnt;
    if (i_load) begin
      w_next = i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      w_next = r_cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_zero      = (r_cnt == '0);
  assign o_next_zero = (w_next == '0);

endmodule
`default_nettype wire

// File: rtl/evt_seq_driver.sv
`default_nettype none
// ============================================================================
// Module : evt_seq_driver
// Desc   : Drives one foo strobe, toggles b, drives REP more strobes, and
//          checks that the consumer level a rises and then falls in time.
// Rev    : 1.0  initial release
// ============================================================================
module evt_seq_driver
  import evt_drv_pkg::*;
#(
  parameter int GAP_W   = 8,
  parameter int REP     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_a,
  output logic             o_foo,
  output logic             o_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  localparam int c_TO_W  = $clog2(TIMEOUT + 1);
  localparam int c_REP_W = $clog2(REP + 1);
  localparam logic [c_TO_W-1:0]  c_TO_LOAD  = c_TO_W'(TIMEOUT);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REP - 1);

  evt_state_t         r_state;
  evt_state_t         w_state_nxt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   w_gap_val;
  logic [c_REP_W-1:0] r_strb_cnt;
  logic               r_foo;
  logic               r_b;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic       w_gap_load;
  logic       w_gap_dec;
  logic       w_gap_zero;
  logic       w_gap_nxt_zero;
  logic       w_to_load;
  logic       w_to_dec;
  logic       w_to_zero;
  logic       w_to_nxt_zero;
  logic       w_to_expire;
  logic       w_accept;
  logic       w_strb_clr;
  logic       w_strb_inc;
  logic       w_err_set;
  logic       w_toggle;
  logic       w_foo_nxt;
  logic [1:0] w_err_code_nxt;

  // Gap reloads after the first come from the value latched at start.
  assign w_gap_val = (r_state == IDLE) ? i_gap : r_gap;

  // Timeout is held at TIMEOUT throughout the gap states so it is full on
  // entry to either wait state, and counts down only while a is unresponsive.
  assign w_to_load   = (r_state == GAP1) || (r_state == GAPN);
  assign w_to_dec    = ((r_state == WAIT_HI) && !i_a) || ((r_state == WAIT_LO) && i_a);
  assign w_to_expire = w_to_dec && (w_to_zero || w_to_nxt_zero);

  evt_down_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_gap_load),
    .i_val       (w_gap_val),
    .i_dec       (w_gap_dec),
    .o_zero      (w_gap_zero),
    .o_next_zero (w_gap_nxt_zero)
  );

  evt_down_timer #(
    .WIDTH (c_TO_W)
  ) u_to_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_to_load),
    .i_val       (c_TO_LOAD),
    .i_dec       (w_to_dec),
    .o_zero      (w_to_zero),
    .o_next_zero (w_to_nxt_zero)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_gap_load     = 1'b0;
    w_gap_dec      = 1'b0;
    w_strb_clr     = 1'b0;
    w_strb_inc     = 1'b0;
    w_err_set      = 1'b0;
    w_toggle       = 1'b0;
    w_err_code_nxt = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_gap_load  = 1'b1;
          w_state_nxt = GAP1;
        end
      end
      GAP1: begin
        if (w_gap_zero) begin
          w_state_nxt = WAIT_HI;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      WAIT_HI: begin
        if (i_a) begin
          w_toggle    = 1'b1;
          w_state_nxt = TOGGLE;
        end else if (w_to_expire) begin
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_NO_RISE;
          w_state_nxt    = FIN;
        end
      end
      TOGGLE: begin
        w_gap_load  = 1'b1;
        w_strb_clr  = 1'b1;
        w_state_nxt = GAPN;
      end
      GAPN: begin
        if (w_gap_zero) begin
          w_strb_inc = 1'b1;
          if (r_strb_cnt == c_REP_LAST) begin
            w_state_nxt = WAIT_LO;
          end else begin
            w_gap_load = 1'b1;
          end
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!i_a) begin
          w_state_nxt = FIN;
        end else if (w_to_expire) begin
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_NO_FALL;
          w_state_nxt    = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // foo is registered, so it is raised on entry to the final cycle of a gap.
  assign w_foo_nxt = ((w_state_nxt == GAP1) || (w_state_nxt == GAPN)) && w_gap_nxt_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_foo      <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_gap      <= '0;
      r_strb_cnt <= '0;
    end else begin
      r_foo  <= w_foo_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FIN);
      if (w_toggle) begin
        r_b <= ~r_b;
      end
      if (w_accept) begin
        r_gap <= i_gap;
      end
      if (w_strb_clr) begin
        r_strb_cnt <= '0;
      end else if (w_strb_inc) begin
        r_strb_cnt <= r_strb_cnt + c_REP_W'(1);
      end
      if (w_accept) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_nxt;
      end
    end
  end

  assign o_foo      = r_foo;
  assign o_b        = r_b;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_evt_seq_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_evt_seq_driver
// Desc   : Self-checking bench for evt_seq_driver: directed table, corner
//          sequences and randomized sequences against a timeline model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_evt_seq_driver;

  localparam int GAP_W   = 8;
  localparam int REP     = 2;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [GAP_W-1:0] gap;
  logic             a;
  logic             foo;
  logic             b;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state carried between sequences.
  bit       m_b    = 1'b0;
  bit       m_err  = 1'b0;
  bit [1:0] m_code = 2'b00;

  evt_seq_driver #(
    .GAP_W   (GAP_W),
    .REP     (REP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_gap      (gap),
    .i_a        (a),
    .o_foo      (foo),
    .o_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_out(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {foo, b, busy, done, err, err_code};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d {foo,b,busy,done,err,code} got %b expected %b",
               name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one sequence from the current drive point (posedge+1). The consumer
  // level a is scheduled from rise offset r (relative to WAIT_HI entry) and
  // fall offset f (relative to WAIT_LO entry); offsets >= TIMEOUT never respond.
  task automatic run_seq(input string name, input int g, input int r, input int f,
                         input int pre_idle, input bit pulse, input bit noise,
                         output int len_seen, output int code_seen);
    int       n0, t, f1, w, s, w2, u, dn;
    bit       rose;
    bit [1:0] code;
    int       strobes[$];
    logic     e_foo, e_b, e_busy, e_done, e_err;
    logic [1:0] e_code;

    n0   = cyc;
    t    = n0 + pre_idle;
    f1   = t + 1 + g;
    w    = f1 + 1;
    rose = (r < TIMEOUT);
    s    = 0;
    u    = 0;
    strobes.push_back(f1);
    if (!rose) begin
      dn   = w + TIMEOUT;
      code = 2'b01;
    end else begin
      s = w + r;
      for (int k = 1; k <= REP; k++) strobes.push_back(s + 1 + k * (g + 1));
      w2 = strobes[REP] + 1;
      if (f < TIMEOUT) begin
        u    = w2 + f;
        dn   = u + 1;
        code = 2'b00;
      end else begin
        u    = w2 + TIMEOUT;
        dn   = w2 + TIMEOUT;
        code = 2'b10;
      end
    end

    len_seen  = -1;
    code_seen = -1;
    for (int n = n0; n <= dn + 1; n++) begin
      start = (n == t) || (pulse && n > t && n <= dn && (((n - t) % 3 == 0) || n == dn));
      gap   = (n == t) ? GAP_W'(g) : GAP_W'($urandom);
      if (noise && n > t && n <= f1) a = ($urandom_range(0, 1) == 1);
      else                           a = rose && (n >= s) && (n < u);
      @(negedge clk);
      e_foo = 1'b0;
      foreach (strobes[k]) if (strobes[k] == n) e_foo = 1'b1;
      e_b    = m_b ^ (rose && (n >= s + 1));
      e_busy = (n > t) && (n <= dn);
      e_done = (n == dn);
      if (n <= t)      begin e_err = m_err;         e_code = m_code; end
      else if (n < dn) begin e_err = 1'b0;          e_code = 2'b00;  end
      else             begin e_err = (code != 0);   e_code = code;   end
      if (done === 1'b1 && len_seen < 0) begin
        len_seen  = n - t;
        code_seen = int'(err_code);
      end
      chk_out(name, {e_foo, e_b, e_busy, e_done, e_err, e_code});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    a     = 1'b0;
    if (rose) m_b = ~m_b;
    m_err  = (code != 0);
    m_code = code;
  endtask

  typedef struct {
    int g;
    int r;
    int f;
    bit noise;
    bit pulse;
    int exp_len;
    int exp_code;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int len, code, t0, s0, rst_cyc;

    vecs[0] = '{3, 1,  0, 1'b0, 1'b0, 17, 0};  // nominal
    vecs[1] = '{0, 0,  0, 1'b0, 1'b0,  7, 0};  // back-to-back strobes
    vecs[2] = '{2, 99, 0, 1'b0, 1'b0, 20, 1};  // a never rises
    vecs[3] = '{1, 3, 99, 1'b0, 1'b0, 28, 2};  // a never falls
    vecs[4] = '{1, 15, 0, 1'b1, 1'b0, 25, 0};  // rise on expiry cycle wins
    vecs[5] = '{0, 0, 15, 1'b0, 1'b1, 22, 0};  // fall on expiry cycle, start spam
    vecs[6] = '{5, 2,  3, 1'b1, 1'b1, 27, 0};

    reset = 1'b1;
    start = 1'b0;
    a     = 1'b0;
    gap   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_values", 7'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_seq($sformatf("vec%0d", i), vecs[i].g, vecs[i].r, vecs[i].f, 1,
              vecs[i].pulse, vecs[i].noise, len, code);
      chk_int($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      chk_int($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
    end

    // Reset in GAPN right after the first post-toggle strobe (gap=2).
    t0      = cyc;
    s0      = t0 + 4;
    rst_cyc = s0 + 1 + 3 + 1;
    for (int n = t0; n < rst_cyc; n++) begin
      start = (n == t0);
      gap   = GAP_W'(2);
      a     = (n >= s0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk_out("pre_reset", {1'b0, ~m_b, 1'b1, 1'b0, 1'b0, 2'b00});
    #2;
    reset = 1'b1;
    #1;
    chk_out("reset_async", 7'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a     = 1'b0;
    m_b    = 1'b0;
    m_err  = 1'b0;
    m_code = 2'b00;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk_out("post_reset_idle", 7'b0);
      @(posedge clk);
      #1;
    end
    run_seq("after_reset", 1, 0, 0, 0, 1'b0, 1'b0, len, code);
    chk_int("after_reset_len", len, 10);
    chk_int("after_reset_code", code, 0);

    for (int i = 0; i < 20; i++) begin
      run_seq("rand", int'($urandom_range(0, 4)), int'($urandom_range(0, 19)),
              int'($urandom_range(0, 19)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 1) == 1), 1'b1, len, code);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
